// File: rtl/env_adsr_pkg.sv
// Shared types and helpers for the ADSR envelope generator / VCA voice stage.
package env_adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

  function automatic logic [15:0] sustain_target(input logic [7:0] sustain_level);
    return {sustain_level, 8'h00};
  endfunction

endpackage

// File: rtl/env_adsr_if.sv
// Voice-path bundle for env_adsr: tick/gate/sample/rates in, scaled sample and envelope status out.
interface env_adsr_if #(
  parameter int RATE_W = 12
);
  import env_adsr_pkg::*;

  logic              sample_tick;
  logic              gate;
  logic [15:0]       sig_in;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [7:0]        sustain_level;
  logic [RATE_W-1:0] release_rate;
  logic [15:0]       sig_out;
  logic              out_valid;
  logic [15:0]       env_level;
  env_state_t        env_state;
  logic              active;

  modport master (
    output sample_tick, gate, sig_in, attack_rate, decay_rate, sustain_level, release_rate,
    input  sig_out, out_valid, env_level, env_state, active
  );

  modport slave (
    input  sample_tick, gate, sig_in, attack_rate, decay_rate, sustain_level, release_rate,
    output sig_out, out_valid, env_level, env_state, active
  );

endinterface

// File: rtl/env_adsr_vca.sv
// Registered signed 16x17 VCA multiply; out_valid pulses the cycle after each sample tick.
module env_adsr_vca (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [15:0] sig_in,
  input  logic [15:0] level,
  output logic [15:0] sig_out,
  output logic        out_valid
);

  logic signed [32:0] product;
  logic               unused_product_bits;

  // Level is unsigned, so it gets a zero sign bit; the product always fits in bits [31:16].
  assign product             = $signed(sig_in) * $signed({1'b0, level});
  assign unused_product_bits = ^{product[32], product[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out   <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sample_tick;
      if (sample_tick) begin
        sig_out <= product[31:16];
      end
    end
  end

endmodule

// File: rtl/env_adsr.sv
// Gated ADSR envelope + VCA. Define ENV_ADSR_LEGATO_EN to ignore retrigger while in DECAY/SUSTAIN.
//
// state      | meaning
// IDLE       | level parked (normally 0), waiting for a rising gate
// ATTACK     | level climbs by attack_rate per tick, saturating at LEVEL_MAX
// DECAY      | level falls by decay_rate per tick, floored at the sustain target
// SUSTAIN    | level tracks the live sustain target every tick
// RELEASE    | level falls by release_rate per tick, floored at 0
module env_adsr
  import env_adsr_pkg::*;
#(
  parameter int RATE_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  env_adsr_if.slave  bus
);

  env_state_t  state_q, state_d, phase;
  logic [15:0] level_q, level_d;
  logic        gate_prev_q;
  logic        rise;
  logic [15:0] target, att_inc, dec_step, rel_step;
  logic [16:0] att_sum;

  assign target   = sustain_target(bus.sustain_level);
  assign att_inc  = {{(16-RATE_W){1'b0}}, bus.attack_rate};
  assign dec_step = {{(16-RATE_W){1'b0}}, bus.decay_rate};
  assign rel_step = {{(16-RATE_W){1'b0}}, bus.release_rate};
  assign rise     = bus.gate & ~gate_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      level_q     <= 16'h0000;
      gate_prev_q <= 1'b0;
    end else if (bus.sample_tick) begin
      state_q     <= state_d;
      level_q     <= level_d;
      gate_prev_q <= bus.gate;
    end
  end

  // Gate events pick the phase for this tick, then that phase's arithmetic runs on the same tick.
  always_comb begin
    phase   = state_q;
    state_d = state_q;
    level_d = level_q;
    att_sum = {1'b0, level_q} + {1'b0, att_inc};

    if (!bus.gate && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      phase = ST_RELEASE;
    end else if (rise) begin
`ifdef ENV_ADSR_LEGATO_EN
      if (state_q == ST_IDLE || state_q == ST_RELEASE) begin
        phase = ST_ATTACK;
      end
`else
      phase = ST_ATTACK;
`endif
    end

    state_d = phase;
    case (phase)
      ST_ATTACK: begin
        if (att_sum >= {1'b0, LEVEL_MAX}) begin
          level_d = LEVEL_MAX;
          state_d = ST_DECAY;
        end else begin
          level_d = att_sum[15:0];
        end
      end
      ST_DECAY: begin
        if (level_q <= target || (level_q - target) <= dec_step) begin
          level_d = target;
          state_d = ST_SUSTAIN;
        end else begin
          level_d = level_q - dec_step;
        end
      end
      ST_SUSTAIN: begin
        level_d = target;
      end
      ST_RELEASE: begin
        if (level_q <= rel_step) begin
          level_d = 16'h0000;
          state_d = ST_IDLE;
        end else begin
          level_d = level_q - rel_step;
        end
      end
      default: begin
        level_d = level_q;
      end
    endcase
  end

  assign bus.env_level = level_q;
  assign bus.env_state = state_q;
  assign bus.active    = (state_q != ST_IDLE);

  // VCA sees level_q, i.e. the level before this tick's envelope update.
  env_adsr_vca u_vca (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (bus.sample_tick),
    .sig_in      (bus.sig_in),
    .level       (level_q),
    .sig_out     (bus.sig_out),
    .out_valid   (bus.out_valid)
  );

endmodule

// File: tb/tb_env_adsr.sv
// Scoreboard bench for env_adsr: directed ADSR walk-through plus randomized ticks vs a reference model.
module tb_env_adsr;
  import env_adsr_pkg::*;

`ifdef ENV_ADSR_LEGATO_EN
  localparam bit LEGATO = 1'b1;
`else
  localparam bit LEGATO = 1'b0;
`endif

  typedef struct {
    logic [15:0] sig;
    int          level;
    int          phase;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Reference model: phase 0..4 as in the datasheet, level as plain integer.
  int m_phase = 0;
  int m_level = 0;
  bit m_gprev = 1'b0;

  env_adsr_if #(.RATE_W(12)) bus ();

  env_adsr #(.RATE_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [15:0] vca_ref(input logic [15:0] s, input int lvl);
    int     si;
    longint p;
    si = $signed(s);
    p  = longint'(si) * longint'(lvl);
    return 16'(p >>> 16);
  endfunction

  function automatic void model_tick(input bit g, input int atk, input int dec, input int sus, input int rel);
    int tgt;
    tgt = sus * 256;
    if (!g && m_phase >= 1 && m_phase <= 3) m_phase = 4;
    else if (g && !m_gprev && (!LEGATO || m_phase == 0 || m_phase == 4)) m_phase = 1;
    m_gprev = g;
    if (m_phase == 1) begin
      m_level = (m_level + atk > 65535) ? 65535 : m_level + atk;
      if (m_level == 65535) m_phase = 2;
    end else if (m_phase == 2) begin
      m_level = (m_level - dec < tgt) ? tgt : m_level - dec;
      if (m_level == tgt) m_phase = 3;
    end else if (m_phase == 3) begin
      m_level = tgt;
    end else if (m_phase == 4) begin
      m_level = (m_level - rel < 0) ? 0 : m_level - rel;
      if (m_level == 0) m_phase = 0;
    end
  endfunction

  task automatic do_tick(input bit g, input logic [15:0] s);
    exp_t e;
    @(negedge clk);
    bus.gate        = g;
    bus.sig_in      = s;
    bus.sample_tick = 1'b1;
    e.sig = vca_ref(s, m_level);
    model_tick(g, int'(bus.attack_rate), int'(bus.decay_rate), int'(bus.sustain_level),
               int'(bus.release_rate));
    e.level = m_level;
    e.phase = m_phase;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit g);
    repeat (n) begin
      @(negedge clk);
      bus.sample_tick = 1'b0;
      bus.gate        = g;
      bus.sig_in      = 16'($urandom);
    end
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.out_valid) begin
        chk("valid_has_expect", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mon_sig_out", 32'(bus.sig_out), 32'(e.sig));
          chk("mon_level", 32'(bus.env_level), 32'(e.level));
          chk("mon_state", 32'(bus.env_state), 32'(e.phase));
          chk("mon_active", 32'(bus.active), 32'(e.phase != 0));
        end
      end
    end
  end

  initial begin
    int n;
    bit g;
    bus.sample_tick   = 1'b0;
    bus.gate          = 1'b0;
    bus.sig_in        = 16'h0000;
    bus.attack_rate   = 12'h800;
    bus.decay_rate    = 12'h100;
    bus.sustain_level = 8'h80;
    bus.release_rate  = 12'hFFF;

    repeat (3) @(negedge clk);
    chk("rst_sig_out", 32'(bus.sig_out), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.env_level), 32'd0);
    chk("rst_state", 32'(bus.env_state), 32'(ST_IDLE));
    chk("rst_active", 32'(bus.active), 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Attack: 0x800 per tick, saturating on tick 32.
    do_tick(1'b1, 16'($urandom));
    chk("atk_tick1_level", 32'(bus.env_level), 32'h0800);
    chk("atk_tick1_state", 32'(bus.env_state), 32'(ST_ATTACK));
    for (int k = 2; k <= 31; k++) do_tick(1'b1, 16'($urandom));
    chk("atk_tick31_level", 32'(bus.env_level), 32'hF800);
    do_tick(1'b1, 16'($urandom));
    chk("atk_tick32_level", 32'(bus.env_level), 32'hFFFF);
    chk("atk_tick32_state", 32'(bus.env_state), 32'(ST_DECAY));

    // Decay to 0x8000 at 0x100 per tick: 128 ticks.
    n = 0;
    while (bus.env_state != ST_SUSTAIN && n < 200) begin
      do_tick(1'b1, 16'($urandom));
      n++;
    end
    chk("decay_ticks", 32'(n), 32'd128);
    chk("decay_level", 32'(bus.env_level), 32'h8000);

    do_tick(1'b1, 16'h4000);
    chk("vca_half", 32'(bus.sig_out), 32'h2000);

    // Gate glitch between ticks must be ignored.
    idle(1, 1'b0);
    idle(1, 1'b1);
    do_tick(1'b1, 16'($urandom));
    chk("glitch_ignored", 32'(bus.env_state), 32'(ST_SUSTAIN));

    bus.sustain_level = 8'h40;
    do_tick(1'b1, 16'($urandom));
    chk("sustain_follow", 32'(bus.env_level), 32'h4000);

    // Release from 0x4000 at 0xFFF: zero on the 5th tick.
    for (int k = 0; k < 4; k++) do_tick(1'b0, 16'($urandom));
    chk("rel_tick4_state", 32'(bus.env_state), 32'(ST_RELEASE));
    chk("rel_tick4_level", 32'(bus.env_level), 32'h0004);
    do_tick(1'b0, 16'($urandom));
    chk("rel_tick5_level", 32'(bus.env_level), 32'd0);
    chk("rel_tick5_state", 32'(bus.env_state), 32'(ST_IDLE));
    chk("rel_tick5_active", 32'(bus.active), 32'd0);

    do_tick(1'b0, 16'h7FFF);
    chk("vca_zero_level", 32'(bus.sig_out), 32'd0);
    idle(2, 1'b0);

    // Re-enter SUSTAIN, then gate 1->0->1 across ticks.
    bus.decay_rate = 12'hFFF;
    n = 0;
    do_tick(1'b1, 16'($urandom));
    while (bus.env_state != ST_SUSTAIN && n < 100) begin
      do_tick(1'b1, 16'($urandom));
      n++;
    end
    chk("resus_state", 32'(bus.env_state), 32'(ST_SUSTAIN));
    do_tick(1'b0, 16'($urandom));
    chk("retrig_release", 32'(bus.env_state), 32'(ST_RELEASE));
    do_tick(1'b1, 16'($urandom));
    chk("retrig_attack", 32'(bus.env_state), 32'(ST_ATTACK));

    // Full-scale negative sample at LEVEL_MAX, held in DECAY by a zero rate.
    bus.decay_rate  = 12'h000;
    bus.attack_rate = 12'hFFF;
    n = 0;
    while (bus.env_state != ST_DECAY && n < 40) begin
      do_tick(1'b1, 16'($urandom));
      n++;
    end
    do_tick(1'b1, 16'h8000);
    chk("vca_fullscale", 32'(bus.sig_out), 32'h8000);
    chk("zero_rate_hold", 32'(bus.env_level), 32'hFFFF);

    n = 0;
    while (bus.env_state != ST_IDLE && n < 40) begin
      do_tick(1'b0, 16'($urandom));
      n++;
    end
    chk("back_to_idle", 32'(bus.env_state), 32'(ST_IDLE));

    // Reset mid-ATTACK with gate held high.
    bus.attack_rate = 12'h100;
    for (int k = 0; k < 3; k++) do_tick(1'b1, 16'($urandom));
    idle(2, 1'b1);
    #3;
    rst_n = 1'b0;
    m_phase = 0;
    m_level = 0;
    m_gprev = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_level", 32'(bus.env_level), 32'd0);
    chk("midrst_state", 32'(bus.env_state), 32'(ST_IDLE));
    chk("midrst_sig_out", 32'(bus.sig_out), 32'd0);
    chk("midrst_active", 32'(bus.active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(1'b1, 16'($urandom));
    chk("postrst_state", 32'(bus.env_state), 32'(ST_ATTACK));
    chk("postrst_level", 32'(bus.env_level), 32'h0100);

    // Randomized run against the model.
    g = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.attack_rate   = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
        bus.decay_rate    = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
        bus.release_rate  = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
        bus.sustain_level = 8'($urandom);
      end
      if ($urandom_range(0, 11) == 0) g = ~g;
      if ($urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
      else do_tick(g, 16'($urandom));
    end

    idle(4, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
